// File: rtl/instr_decode_pipe_if.sv
// ID/EX bus: valid/ready handshake plus the decoded instruction payload.
// master = decode stage (drives the slot), slave = execute stage (drives ready).
interface instr_decode_pipe_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              out_valid;
    logic              out_ready;
    logic [2:0]        alu_opcode;
    logic [4:0]        memory_access_code;
    logic [2:0]        audio_opcode;
    logic [DATA_W-1:0] operand_value1;
    logic [DATA_W-1:0] operand_value2;
    logic [1:0]        register_writeback_enable;
    logic [2:0]        writeback_register_encoding;
    logic [3:0]        writeback_data_select_hotcode;
    logic [CH_W-1:0]   audio_channel_select;
    logic [31:0]       id_ex_instruction;
    logic              illegal_ch;

    modport master (
        output out_valid, alu_opcode, memory_access_code, audio_opcode,
               operand_value1, operand_value2, register_writeback_enable,
               writeback_register_encoding, writeback_data_select_hotcode,
               audio_channel_select, id_ex_instruction, illegal_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid, alu_opcode, memory_access_code, audio_opcode,
               operand_value1, operand_value2, register_writeback_enable,
               writeback_register_encoding, writeback_data_select_hotcode,
               audio_channel_select, id_ex_instruction, illegal_ch,
        output out_ready
    );
endinterface

// File: rtl/instr_decode_pipe.sv
// Instruction decode stage: decodes the IF/ID word into the ID/EX slot with
// valid/ready flow control, a per-register load-use scoreboard that inserts
// bubbles, flush, and illegal audio-channel detection.
module instr_decode_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 4,
    parameter int LOAD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       if_id_reg,
    output logic [2:0]        register_select_1,
    output logic [2:0]        register_select_2,
    input  logic [DATA_W-1:0] selected_register_value_1,
    input  logic [DATA_W-1:0] selected_register_value_2,
    instr_decode_pipe_if.master id_ex
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic        imm_bit;
    logic [1:0]  typ;
    logic [2:0]  op;
    logic [1:0]  ch;
    logic [2:0]  rd;
    logic [15:0] immv;

    assign imm_bit           = if_id_reg[31];
    assign typ               = if_id_reg[30:29];
    assign op                = if_id_reg[28:26];
    assign ch                = if_id_reg[25:24];
    assign rd                = if_id_reg[21:19];
    assign immv              = if_id_reg[15:0];
    assign register_select_1 = if_id_reg[21:19];
    assign register_select_2 = if_id_reg[18:16];

    logic [2:0] cnt [8];

    logic is_nop, is_move, is_arith, is_mem, is_audio;
    logic mv_low, mv_up, is_load, illegal;
    logic use1, use2, hazard, advance, transfer;

    logic [2:0]        d_alu;
    logic [4:0]        d_mem;
    logic [2:0]        d_aud;
    logic [DATA_W-1:0] d_op1;
    logic [DATA_W-1:0] d_op2;
    logic [1:0]        d_wb;
    logic [3:0]        d_hot;
    logic [CH_W-1:0]   d_ch;
    logic [31:0]       d_instr;

    // Classify the instruction and form every field of the next ID/EX slot.
    always_comb begin
        is_nop   = (typ == 2'b00);
        is_move  = (typ == 2'b01) && (op == 3'b101 || op == 3'b110 || op == 3'b111);
        is_arith = (typ == 2'b01) && !is_move;
        is_mem   = (typ == 2'b10);
        is_audio = (typ == 2'b11);
        mv_low   = is_move && (op == 3'b101);
        mv_up    = is_move && (op == 3'b110);
        is_load  = is_mem && (op == 3'b001 || op == 3'b010);
        illegal  = is_audio && ({1'b0, ch} >= 3'(NUM_CH));

        use1 = !is_nop
            && !((mv_low || mv_up) && imm_bit)
            && !(is_audio && imm_bit && (op == 3'b100 || op == 3'b110));
        use2 = !is_nop && !imm_bit;

        d_alu   = is_arith ? op : 3'd0;
        d_mem   = is_mem ? {op[2], op[1], op[1], op[0], op[0]} : 5'd0;
        d_aud   = (is_audio && !illegal) ? op : 3'd0;
        d_hot   = {is_arith, is_mem, is_move, is_nop | is_audio};
        d_ch    = (is_audio && !illegal) ? ch[CH_W-1:0] : '0;
        d_instr = illegal ? 32'd0 : if_id_reg;

        if (mv_low || (is_mem && op == 3'b001))
            d_wb = 2'b01;
        else if (mv_up || (is_mem && op == 3'b010))
            d_wb = 2'b10;
        else if (is_arith || is_move)
            d_wb = 2'b11;
        else
            d_wb = 2'b00;

        d_op1 = selected_register_value_1;
        d_op2 = selected_register_value_2;
        if (imm_bit) begin
            if (is_arith || is_mem || mv_low) begin
                d_op2       = '0;
                d_op2[15:0] = immv;
            end else if (mv_up) begin
                d_op2        = '0;
                d_op2[31:16] = immv;
            end else if (is_audio && op == 3'b100) begin
                d_op1        = '0;
                d_op1[31:16] = immv;
            end else if (is_audio && op == 3'b110) begin
                d_op1       = '0;
                d_op1[23:8] = immv;
            end
        end
    end

    // Handshake: stall on scoreboard hit, never accept during reset or flush.
    always_comb begin
        advance  = !id_ex.out_valid || id_ex.out_ready;
        hazard   = in_valid && ((use1 && cnt[register_select_1] != 3'd0) ||
                                (use2 && cnt[register_select_2] != 3'd0));
        in_ready = advance && !hazard && !reset && !flush;
        transfer = in_valid && in_ready;
    end

    // ID/EX slot and scoreboard; a load's fresh count overrides the decrement.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            id_ex.out_valid                     <= 1'b0;
            id_ex.alu_opcode                    <= '0;
            id_ex.memory_access_code            <= '0;
            id_ex.audio_opcode                  <= '0;
            id_ex.operand_value1                <= '0;
            id_ex.operand_value2                <= '0;
            id_ex.register_writeback_enable     <= '0;
            id_ex.writeback_register_encoding   <= '0;
            id_ex.writeback_data_select_hotcode <= '0;
            id_ex.audio_channel_select          <= '0;
            id_ex.id_ex_instruction             <= '0;
            id_ex.illegal_ch                    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++)
                cnt[i] <= '0;
        end else begin
            id_ex.illegal_ch <= transfer && illegal;
            if (advance) begin
                for (int unsigned i = 0; i < 8; i++)
                    if (cnt[i] != 3'd0)
                        cnt[i] <= cnt[i] - 3'd1;
                if (transfer) begin
                    id_ex.out_valid                     <= 1'b1;
                    id_ex.alu_opcode                    <= d_alu;
                    id_ex.memory_access_code            <= d_mem;
                    id_ex.audio_opcode                  <= d_aud;
                    id_ex.operand_value1                <= d_op1;
                    id_ex.operand_value2                <= d_op2;
                    id_ex.register_writeback_enable     <= d_wb;
                    id_ex.writeback_register_encoding   <= rd;
                    id_ex.writeback_data_select_hotcode <= d_hot;
                    id_ex.audio_channel_select          <= d_ch;
                    id_ex.id_ex_instruction             <= d_instr;
                    if (is_load)
                        cnt[rd] <= 3'(LOAD_LAT);
                end else begin
                    id_ex.out_valid                     <= 1'b0;
                    id_ex.alu_opcode                    <= '0;
                    id_ex.memory_access_code            <= '0;
                    id_ex.audio_opcode                  <= '0;
                    id_ex.operand_value1                <= '0;
                    id_ex.operand_value2                <= '0;
                    id_ex.register_writeback_enable     <= '0;
                    id_ex.writeback_register_encoding   <= '0;
                    id_ex.writeback_data_select_hotcode <= '0;
                    id_ex.audio_channel_select          <= '0;
                    id_ex.id_ex_instruction             <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed bench for instr_decode_pipe: one instance with 4 channels and one
// with 2 channels share the same stimulus; expected values are hand-computed.
module tb_instr_decode_pipe;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid;
    logic [31:0] if_id_reg;
    logic        in_ready_a, in_ready_b;
    logic [2:0]  rs1_a, rs2_a, rs1_b, rs2_b;
    logic [31:0] rv1_a, rv2_a, rv1_b, rv2_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    // Register file contents: register r reads as 0xA500000r.
    assign rv1_a = 32'hA500_0000 | {29'd0, rs1_a};
    assign rv2_a = 32'hA500_0000 | {29'd0, rs2_a};
    assign rv1_b = 32'hA500_0000 | {29'd0, rs1_b};
    assign rv2_b = 32'hA500_0000 | {29'd0, rs2_b};

    instr_decode_pipe_if #(.DATA_W(32), .NUM_CH(4)) bus_a ();
    instr_decode_pipe_if #(.DATA_W(32), .NUM_CH(2)) bus_b ();

    instr_decode_pipe #(.DATA_W(32), .NUM_CH(4), .LOAD_LAT(2)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_a), .if_id_reg(if_id_reg),
        .register_select_1(rs1_a), .register_select_2(rs2_a),
        .selected_register_value_1(rv1_a), .selected_register_value_2(rv2_a),
        .id_ex(bus_a)
    );

    instr_decode_pipe #(.DATA_W(32), .NUM_CH(2), .LOAD_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_b), .if_id_reg(if_id_reg),
        .register_select_1(rs1_b), .register_select_2(rs2_b),
        .selected_register_value_1(rv1_b), .selected_register_value_2(rv2_b),
        .id_ex(bus_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ready(input logic r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; if_id_reg = '0;
        set_ready(1'b1);
        tick(); tick();

        // Reset state
        check("rst_valid", bus_a.out_valid, 0);
        check("rst_instr", bus_a.id_ex_instruction, 0);
        check("rst_op1", bus_a.operand_value1, 0);
        check("rst_hot", bus_a.writeback_data_select_hotcode, 0);
        check("rst_in_ready", in_ready_a, 0);
        reset = 1'b0;
        #1 check("idle_in_ready", in_ready_a, 1);

        // Arithmetic add r1,r2
        in_valid = 1'b1; if_id_reg = 32'h200A_0000;
        #1 check("add_rs1", rs1_a, 1);
        check("add_rs2", rs2_a, 2);
        check("add_in_ready", in_ready_a, 1);
        tick(); in_valid = 1'b0;
        check("add_valid", bus_a.out_valid, 1);
        check("add_alu", bus_a.alu_opcode, 0);
        check("add_wb", bus_a.register_writeback_enable, 2'b11);
        check("add_hot", bus_a.writeback_data_select_hotcode, 4'b1000);
        check("add_op1", bus_a.operand_value1, 32'hA500_0001);
        check("add_op2", bus_a.operand_value2, 32'hA500_0002);
        check("add_instr", bus_a.id_ex_instruction, 32'h200A_0000);
        check("add_mem", bus_a.memory_access_code, 0);

        // Move-up immediate
        in_valid = 1'b1; if_id_reg = 32'hB828_ABCD;
        tick(); in_valid = 1'b0;
        check("mvu_op2", bus_a.operand_value2, 32'hABCD_0000);
        check("mvu_wb", bus_a.register_writeback_enable, 2'b10);
        check("mvu_wbreg", bus_a.writeback_register_encoding, 5);
        check("mvu_hot", bus_a.writeback_data_select_hotcode, 4'b0010);
        check("mvu_alu", bus_a.alu_opcode, 0);
        tick();
        check("bubble_valid", bus_a.out_valid, 0);
        check("bubble_instr", bus_a.id_ex_instruction, 0);

        // Move-low immediate
        in_valid = 1'b1; if_id_reg = 32'hB410_1234;
        tick(); in_valid = 1'b0;
        check("mvl_op2", bus_a.operand_value2, 32'h0000_1234);
        check("mvl_wb", bus_a.register_writeback_enable, 2'b01);
        check("mvl_wbreg", bus_a.writeback_register_encoding, 2);

        // Audio op 100 with immediate, ch 1 (legal for both instances)
        in_valid = 1'b1; if_id_reg = 32'hF100_00FF;
        tick(); in_valid = 1'b0;
        check("aud_op1", bus_a.operand_value1, 32'h00FF_0000);
        check("aud_opc", bus_a.audio_opcode, 4);
        check("aud_ch", bus_a.audio_channel_select, 1);
        check("aud_hot", bus_a.writeback_data_select_hotcode, 4'b0001);
        check("aud_wb", bus_a.register_writeback_enable, 0);
        check("aud_ch2_illegal", bus_b.illegal_ch, 0);

        // Load-use: load r3 then add r3,r4
        in_valid = 1'b1; if_id_reg = 32'hC418_0010;
        #1 check("ld_in_ready", in_ready_a, 1);
        tick();
        if_id_reg = 32'h201C_0000;
        check("ld_valid", bus_a.out_valid, 1);
        check("ld_mem", bus_a.memory_access_code, 5'b00011);
        check("ld_wb", bus_a.register_writeback_enable, 2'b01);
        check("ld_op2", bus_a.operand_value2, 32'h10);
        #1 check("lu_stall0", in_ready_a, 0);
        tick();
        check("lu_bubble1", bus_a.out_valid, 0);
        check("lu_stall1", in_ready_a, 0);
        tick();
        check("lu_bubble2", bus_a.out_valid, 0);
        check("lu_release", in_ready_a, 1);
        tick(); in_valid = 1'b0;
        check("lu_add_valid", bus_a.out_valid, 1);
        check("lu_add_instr", bus_a.id_ex_instruction, 32'h201C_0000);
        check("lu_add_op1", bus_a.operand_value1, 32'hA500_0003);
        check("lu_add_op2", bus_a.operand_value2, 32'hA500_0004);

        // Backpressure: slot must hold for 3 cycles
        in_valid = 1'b1; if_id_reg = 32'h200A_0000;
        tick();
        set_ready(1'b0);
        if_id_reg = 32'hB410_1234;
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", in_ready_a, 0);
            tick();
            check("bp_valid", bus_a.out_valid, 1);
            check("bp_instr", bus_a.id_ex_instruction, 32'h200A_0000);
            check("bp_op1", bus_a.operand_value1, 32'hA500_0001);
        end
        set_ready(1'b1);
        #1 check("bp_release", in_ready_a, 1);
        tick(); in_valid = 1'b0;
        check("bp_next", bus_a.id_ex_instruction, 32'hB410_1234);

        // Illegal channel: audio op 010 on ch 3
        in_valid = 1'b1; if_id_reg = 32'h6B00_0000;
        tick(); in_valid = 1'b0;
        check("ill_pulse", bus_b.illegal_ch, 1);
        check("ill_valid", bus_b.out_valid, 1);
        check("ill_instr", bus_b.id_ex_instruction, 0);
        check("ill_hot", bus_b.writeback_data_select_hotcode, 4'b0001);
        check("ill_aud", bus_b.audio_opcode, 0);
        check("ch4_no_flag", bus_a.illegal_ch, 0);
        check("ch4_aud", bus_a.audio_opcode, 2);
        check("ch4_instr", bus_a.id_ex_instruction, 32'h6B00_0000);
        tick();
        check("ill_pulse_end", bus_b.illegal_ch, 0);

        // Flush during load-use hazard
        in_valid = 1'b1; if_id_reg = 32'hC418_0010;
        tick();
        if_id_reg = 32'h201C_0000; flush = 1'b1;
        #1 check("fl_in_ready", in_ready_a, 0);
        tick(); flush = 1'b0;
        check("fl_valid", bus_a.out_valid, 0);
        #1 check("fl_sb_clear", in_ready_a, 1);
        tick(); in_valid = 1'b0;
        check("fl_add_valid", bus_a.out_valid, 1);
        check("fl_add_instr", bus_a.id_ex_instruction, 32'h201C_0000);

        // Reset during load-use hazard
        in_valid = 1'b1; if_id_reg = 32'hC418_0010;
        tick();
        if_id_reg = 32'h201C_0000; reset = 1'b1;
        tick();
        check("rh_valid", bus_a.out_valid, 0);
        check("rh_instr", bus_a.id_ex_instruction, 0);
        check("rh_wb", bus_a.register_writeback_enable, 0);
        check("rh_op2", bus_a.operand_value2, 0);
        check("rh_in_ready", in_ready_a, 0);
        reset = 1'b0;
        #1 check("rh_sb_clear", in_ready_a, 1);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
